// File: rtl/link_tx_fifo.sv
// Per-channel elastic transmit FIFOs feeding the inter-FPGA link, plus the per-channel quiescence flag.
// Define LINK_FIFO_BYPASS_EN to let a word cut through an empty channel in the same cycle.
module link_tx_fifo #(
    parameter int WIDTH    = 128,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH*CHANNELS-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    input  logic [CHANNELS-1:0]       local_busy,
    output logic [CHANNELS-1:0]       has_message_flying,
    output logic [CW*CHANNELS-1:0]    occupancy
);

    localparam int AW = $clog2(DEPTH);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;
        logic             empty;
        logic             full;
        logic             push;
        logic             wr_en;
        logic             rd_en;
        logic [WIDTH-1:0] head;

        assign empty = (count == '0);
        assign full  = (count == CW'(DEPTH));
        // Readiness is purely state-based so out_ready never reaches in_ready combinationally.
        assign in_ready[c] = reset & ~full;
        assign push        = in_valid[c] & in_ready[c];
        assign head        = mem[rd_ptr];
        assign rd_en       = ~empty & out_ready[c];

`ifdef LINK_FIFO_BYPASS_EN
        logic thru;

        // An accepted cut-through word never touches the buffer.
        assign thru         = empty & push & out_ready[c];
        assign wr_en        = push & ~thru;
        assign out_valid[c] = ~empty | (reset & in_valid[c]);
        assign out_data[c*WIDTH +: WIDTH] = empty ? in_data[c*WIDTH +: WIDTH] : head;
`else
        assign wr_en        = push;
        assign out_valid[c] = ~empty;
        assign out_data[c*WIDTH +: WIDTH] = head;
`endif

        assign has_message_flying[c]  = ~empty | in_valid[c] | local_busy[c];
        assign occupancy[c*CW +: CW] = count;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                if (wr_en && !rd_en)      count <= count + CW'(1);
                else if (rd_en && !wr_en) count <= count - CW'(1);
            end
        end

        // Storage carries no reset; contents are only meaningful below count.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= in_data[c*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_link_tx_fifo.sv
// Scoreboard bench for link_tx_fifo: stimulus queues expected words per channel, a negedge monitor checks every handshake.
`timescale 1ns/1ps
module tb_link_tx_fifo;

    localparam int WIDTH    = 128;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 8;
    localparam int CW       = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic [WIDTH*CHANNELS-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH*CHANNELS-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS-1:0]       local_busy;
    logic [CHANNELS-1:0]       has_message_flying;
    logic [CW*CHANNELS-1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q [CHANNELS][$];

    always #5 clk = ~clk;

    link_tx_fifo #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .local_busy(local_busy),
        .has_message_flying(has_message_flying),
        .occupancy(occupancy)
    );

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic v, input logic [WIDTH-1:0] d);
        in_valid[c] = v;
        in_data[c*WIDTH +: WIDTH] = d;
    endtask

    function automatic logic [CW-1:0] occ(input int c);
        return occupancy[c*CW +: CW];
    endfunction

    task automatic drain(input int c, input string name);
        out_ready[c] = 1'b1;
        for (int k = 0; k < 40 && out_valid[c]; k++) tick();
        chk(name, out_valid[c], 0);
        out_ready[c] = 1'b0;
    endtask

    // Monitor: every accepted head word must match the oldest expected word of its channel.
    always @(negedge clk) begin
        logic [WIDTH-1:0] want;
        for (int c = 0; c < CHANNELS; c++) begin
            if (out_valid[c] && out_ready[c]) begin
                if (exp_q[c].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_ch%0d: got %0h, expected no output", c, out_data[c*WIDTH +: WIDTH]);
                end else begin
                    want = exp_q[c].pop_front();
                    chk($sformatf("out_ch%0d", c), out_data[c*WIDTH +: WIDTH], want);
                end
            end
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        logic tog;
        logic stall;
        logic accepted;
        logic [WIDTH-1:0] held;

        reset      = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = '0;
        local_busy = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and flying flag while held in reset
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        local_busy = 4'b0010;
        in_valid   = 4'b0100;
        #1 chk("rst_flying", has_message_flying, 4'b0110);
        local_busy = '0;
        in_valid   = '0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("release_in_ready", in_ready, 4'hF);
        chk("release_out_valid", out_valid, 0);
        tick();

        // Fill ch0 with 1..8, then drain in order
        for (int i = 1; i <= 8; i++) begin
            chk("fill_in_ready", in_ready[0], 1);
            drive(0, 1'b1, WIDTH'(i));
            exp_q[0].push_back(WIDTH'(i));
            tick();
        end
        drive(0, 1'b0, '0);
        chk("full_in_ready", in_ready[0], 0);
        chk("full_occ", occ(0), 8);
        chk("full_out_valid", out_valid[0], 1);
        out_ready[0] = 1'b1;
        #1 chk("full_ready_no_comb", in_ready[0], 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", out_valid[0], 1);
            tick();
            if (i == 0) chk("drain_in_ready", in_ready[0], 1);
        end
        chk("drained_valid", out_valid[0], 0);
        chk("drained_occ", occ(0), 0);
        out_ready[0] = 1'b0;

        // Full with simultaneous push and pop: pop wins, push refused
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, WIDTH'('h11 + i));
            exp_q[0].push_back(WIDTH'('h11 + i));
            tick();
        end
        drive(0, 1'b1, WIDTH'('h99));
        out_ready[0] = 1'b1;
        #1 chk("fullpp_in_ready", in_ready[0], 0);
        tick();
        chk("fullpp_occ7", occ(0), 7);
        chk("fullpp_ready_back", in_ready[0], 1);
        exp_q[0].push_back(WIDTH'('h99));
        tick();
        chk("fullpp_occ_steady", occ(0), 7);
        drive(0, 1'b1, WIDTH'('h9A));
        exp_q[0].push_back(WIDTH'('h9A));
        tick();
        chk("fullpp_occ_steady2", occ(0), 7);
        drive(0, 1'b0, '0);
        drain(0, "fullpp_drain");

        // Stream 20 words through ch2 with out_ready toggling; pointers wrap twice
        idx = 0;
        cyc = 0;
        tog = 1'b1;
        while ((idx < 20 || exp_q[2].size() != 0) && cyc < 200) begin
            out_ready[2] = tog;
            tog = ~tog;
            if (idx < 20) drive(2, 1'b1, WIDTH'('h200 + idx));
            else          drive(2, 1'b0, '0);
            #1;
            stall    = out_valid[2] & ~out_ready[2];
            held     = out_data[2*WIDTH +: WIDTH];
            accepted = (idx < 20) && in_ready[2];
            if (accepted) exp_q[2].push_back(WIDTH'('h200 + idx));
            tick();
            if (stall) begin
                chk("stall_valid", out_valid[2], 1);
                chk("stall_data", out_data[2*WIDTH +: WIDTH], held);
            end
            if (accepted) idx++;
            cyc++;
        end
        chk("stream_count", idx, 20);
        chk("stream_q_empty", exp_q[2].size(), 0);
        drive(2, 1'b0, '0);
        out_ready[2] = 1'b0;

        // ch1 stalled full while ch3 streams A0..A9 uninterrupted
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'b1, WIDTH'('h100 + i));
            exp_q[1].push_back(WIDTH'('h100 + i));
            tick();
        end
        drive(1, 1'b1, WIDTH'('h1FF));
        out_ready[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("ch3_in_ready", in_ready[3], 1);
            drive(3, 1'b1, WIDTH'('hA0 + i));
            exp_q[3].push_back(WIDTH'('hA0 + i));
            tick();
            chk("ch3_out_valid", out_valid[3], 1);
            chk("ch1_stalled_ready", in_ready[1], 0);
        end
        drive(3, 1'b0, '0);
        drive(1, 1'b0, '0);
        chk("ch1_occ", occ(1), 8);
        drain(3, "ch3_drain");
        drain(1, "ch1_drain");

        // Flying status
        chk("flying_idle", has_message_flying, 0);
        local_busy[3] = 1'b1;
        #1 chk("flying_busy3", has_message_flying, 4'b1000);
        local_busy = '0;
        drive(0, 1'b1, WIDTH'('h77));
        #1 chk("flying_in_valid", has_message_flying, 4'b0001);
        exp_q[0].push_back(WIDTH'('h77));
        tick();
        drive(0, 1'b0, '0);
        #1 chk("flying_stored", has_message_flying, 4'b0001);
        tick();
        chk("flying_stored2", has_message_flying, 4'b0001);
        out_ready[0] = 1'b1;
        #1 chk("flying_pre_pop", has_message_flying, 4'b0001);
        tick();
        chk("flying_after_pop", has_message_flying, 4'b0000);
        out_ready[0] = 1'b0;

        // Reset mid-operation discards 5 held entries
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, WIDTH'('h31 + i));
            tick();
        end
        drive(0, 1'b0, '0);
        chk("pre_rst_occ", occ(0), 5);
        chk("pre_rst_valid", out_valid[0], 1);
        #2 reset = 1'b0;
        #1 chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_occ", occupancy, 0);
        tick();
        chk("midrst_occ_hold", occupancy, 0);
        #2 reset = 1'b1;
        #1 chk("midrst_release_ready", in_ready, 4'hF);
        chk("midrst_release_occ", occ(0), 0);
        tick();
        drive(0, 1'b1, WIDTH'('h55));
        out_ready[0] = 1'b1;
        exp_q[0].push_back(WIDTH'('h55));
        #1;
`ifdef LINK_FIFO_BYPASS_EN
        chk("post_rst_bypass_valid", out_valid[0], 1);
        chk("post_rst_bypass_data", out_data[WIDTH-1:0], WIDTH'('h55));
        tick();
        drive(0, 1'b0, '0);
`else
        chk("post_rst_no_early_valid", out_valid[0], 0);
        tick();
        drive(0, 1'b0, '0);
        chk("post_rst_valid", out_valid[0], 1);
        chk("post_rst_data", out_data[WIDTH-1:0], WIDTH'('h55));
`endif
        drain(0, "post_rst_drain");

        repeat (2) tick();
        for (int c = 0; c < CHANNELS; c++)
            chk($sformatf("q_empty_ch%0d", c), exp_q[c].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
